// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and defaults for the memory port arbiter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter with zero flag for memory latency
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // load wins over decrement; the counter parks at its value when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and MEM stages with D priority
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IFReq,
  input  logic [ADDR_W-1:0] IFAddr,
  output logic [DATA_W-1:0] IFRData,
  output logic              IFReady,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DReady,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state;
  owner_t           owner;
  logic             if_done;
  logic             d_done;
  logic             pend_d;
  logic             pend_if;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign pend_d  = DReq & ~d_done;
  assign pend_if = IFReq & ~if_done;

  // a Ready pulse counts as completion in its own cycle so the pipeline can advance on it
  assign Stall = (IFReq & ~(if_done | IFReady)) | (DReq & ~(d_done | DReady));

  // writes need no read latency, so they skip straight to the response
  assign cnt_load = (state == IDLE) && (pend_d || pend_if);
  assign cnt_val  = (pend_d && DWrite) ? '0 : CNT_W'(MEM_LAT);
  assign cnt_dec  = (state == WAIT) && !cnt_zero;

  mem_lat_counter #(
    .W(CNT_W)
  ) u_lat (
    .clk      (Clk),
    .rst      (Rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // arbitration FSM with registered memory strobes, read data, ready pulses and done flags
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      MemEn    <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      IFRData  <= '0;
      DRData   <= '0;
      IFReady  <= 1'b0;
      DReady   <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      MemEn   <= 1'b0;
      IFReady <= 1'b0;
      DReady  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_d) begin
            owner    <= OWN_D;
            MemAddr  <= DAddr;
            MemWe    <= DWrite;
            MemWData <= DWData;
            MemEn    <= 1'b1;
            state    <= WAIT;
          end else if (pend_if) begin
            owner   <= OWN_IF;
            MemAddr <= IFAddr;
            MemWe   <= 1'b0;
            MemEn   <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            if (owner == OWN_D) begin
              if (!MemWe) DRData <= MemRData;
              DReady <= 1'b1;
            end else begin
              IFRData <= MemRData;
              IFReady <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // a request dropped mid-access (flush) completes but leaves no done flag
          if (owner == OWN_D && DReq) d_done <= 1'b1;
          if (owner == OWN_IF && IFReq) if_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // pipeline advances on this edge: the next cycle's requests are new
      if (!Stall) begin
        if_done <= 1'b0;
        d_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IFReq, DReq, DWrite;
  logic [31:0] IFAddr, DAddr, DWData;
  logic [31:0] IFRData, DRData, MemAddr, MemWData, MemRData;
  logic        IFReady, DReady, MemEn, MemWe, Stall;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  logic        mem_init;
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] pipe    [0:LAT-1];

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, wd;
    int          exp_c, exp_en;
    logic [31:0] exp_if, exp_d;
  } vec_t;

  vec_t tbl [7];

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .IFReq(IFReq), .IFAddr(IFAddr), .IFRData(IFRData), .IFReady(IFReady),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DReady(DReady),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .Stall(Stall)
  );

  // memory model: reads appear LAT cycles after MemEn, garbage otherwise
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
      mem[1]    <= 32'h8C220000;
      mem[8'h10] <= 32'h00000011;
    end else if (MemEn && MemWe) begin
      mem[MemAddr[9:2]] <= MemWData;
    end
    pipe[0] <= (MemEn && !MemWe) ? mem[MemAddr[9:2]] : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign MemRData = pipe[LAT-1];

  always @(negedge Clk) if (MemEn) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input string name, input int n, input logic [15:0] en_m,
                            input logic [15:0] we_m, input logic [15:0] ifr_m,
                            input logic [15:0] dr_m, input logic [15:0] st_m);
    for (int c = 0; c < n; c++) begin
      #1;
      chk($sformatf("%s c%0d MemEn", name, c), 32'(MemEn), 32'(en_m[c]));
      chk($sformatf("%s c%0d MemWe", name, c), 32'(MemEn & MemWe), 32'(we_m[c]));
      chk($sformatf("%s c%0d IFReady", name, c), 32'(IFReady), 32'(ifr_m[c]));
      chk($sformatf("%s c%0d DReady", name, c), 32'(DReady), 32'(dr_m[c]));
      chk($sformatf("%s c%0d Stall", name, c), 32'(Stall), 32'(st_m[c]));
      @(posedge Clk); #1;
    end
  endtask

  task automatic idle(input int n);
    IFReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic run_step(input string name, input logic ir, input logic dr, input logic dw,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          input int exp_c, input int exp_en,
                          input logic [31:0] exp_if, input logic [31:0] exp_d);
    int en0;
    int c;
    en0 = en_cnt;
    IFReq = ir; DReq = dr; DWrite = dw; IFAddr = ia; DAddr = da; DWData = wd;
    #1;
    c = 0;
    while (Stall && c < 64) begin
      @(posedge Clk); #1;
      c++;
    end
    chk({name, " cycles"}, 32'(c), 32'(exp_c));
    chk({name, " IFRData"}, IFRData, exp_if);
    chk({name, " DRData"}, DRData, exp_d);
    @(posedge Clk); #1;
    chk({name, " mem_en_count"}, 32'(en_cnt - en0), 32'(exp_en));
  endtask

  initial begin
    logic        ir, dr, dw;
    logic [31:0] ia, da, wd, eif, ed;
    int          ec, een, mism;

    Rst = 1'b1; mem_init = 1'b1;
    IFReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    IFAddr = '0; DAddr = '0; DWData = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | i;
    ref_mem[1]     = 32'h8C220000;
    ref_mem[8'h10] = 32'h00000011;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst MemEn", 32'(MemEn), 0);
    chk("rst MemWe", 32'(MemWe), 0);
    chk("rst MemAddr", MemAddr, 0);
    chk("rst MemWData", MemWData, 0);
    chk("rst IFRData", IFRData, 0);
    chk("rst DRData", DRData, 0);
    chk("rst IFReady", 32'(IFReady), 0);
    chk("rst DReady", 32'(DReady), 0);
    chk("rst Stall idle", 32'(Stall), 0);
    IFReq = 1'b1; #1;
    chk("rst Stall req", 32'(Stall), 1);
    mem_init = 1'b0; Rst = 1'b0; IFReq = 1'b0;
    @(posedge Clk); #1;

    // IF read alone
    IFReq = 1'b1; IFAddr = 32'h4;
    run_cycles("t1", 5, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h000F);
    chk("t1 IFRData", IFRData, 32'h8C220000);
    idle(2);

    // IF and D read in the same cycle, D first
    en_cnt = 0;
    IFReq = 1'b1; IFAddr = 32'h8; DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h40;
    run_cycles("t2", 10, 16'h0042, 16'h0000, 16'h0200, 16'h0010, 16'h01FF);
    chk("t2 DRData", DRData, 32'h11);
    chk("t2 IFRData", IFRData, 32'hC0DE0002);
    chk("t2 mem_en_count", 32'(en_cnt), 2);
    idle(2);

    // D store
    DReq = 1'b1; DWrite = 1'b1; DAddr = 32'h40; DWData = 32'hAA;
    run_cycles("t3", 3, 16'h0002, 16'h0002, 16'h0000, 16'h0004, 16'h0003);
    idle(1);
    ref_mem[8'h10] = 32'hAA;
    chk("t3 mem", mem[8'h10], 32'hAA);
    chk("t3 DRData held", DRData, 32'h11);
    idle(1);

    // D store held while IF read still pending: D issued once
    en_cnt = 0;
    IFReq = 1'b1; IFAddr = 32'h8; DReq = 1'b1; DWrite = 1'b1; DAddr = 32'h80; DWData = 32'h55;
    run_cycles("t6", 8, 16'h0012, 16'h0002, 16'h0080, 16'h0004, 16'h007F);
    ref_mem[8'h20] = 32'h55;
    chk("t6 mem_en_count", 32'(en_cnt), 2);
    chk("t6 mem", mem[8'h20], 32'h55);
    idle(2);

    // flush: IFReq dropped mid-read, then a new fetch
    IFReq = 1'b1; IFAddr = 32'h4;
    run_cycles("t5a", 2, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0003);
    IFReq = 1'b0;
    run_cycles("t5b", 4, 16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0000);
    IFReq = 1'b1; IFAddr = 32'hC;
    run_cycles("t5c", 5, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h000F);
    chk("t5 IFRData", IFRData, 32'hC0DE0003);
    idle(2);

    // reset in the middle of an IF read
    IFReq = 1'b1; IFAddr = 32'h4;
    run_cycles("t4a", 2, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0003);
    Rst = 1'b1; #1;
    chk("t4 MemEn", 32'(MemEn), 0);
    chk("t4 MemWe", 32'(MemWe), 0);
    chk("t4 MemAddr", MemAddr, 0);
    chk("t4 MemWData", MemWData, 0);
    chk("t4 IFRData", IFRData, 0);
    chk("t4 DRData", DRData, 0);
    chk("t4 IFReady", 32'(IFReady), 0);
    chk("t4 DReady", 32'(DReady), 0);
    chk("t4 Stall", 32'(Stall), 1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    run_cycles("t4b", 5, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h000F);
    chk("t4 IFRData after", IFRData, 32'h8C220000);
    idle(2);

    // table-driven transactions
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        4, 1, 32'hC0DE0040, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h104, 32'h0,        4, 1, 32'hC0DE0040, 32'hC0DE0041};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h104, 32'h12345678, 7, 2, 32'h12345678, 32'hC0DE0041};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        0, 0, 32'h12345678, 32'hC0DE0041};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h104, 32'h0,        9, 2, 32'hC0DE0042, 32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h10C, 32'hFFFFFFFF, 2, 1, 32'hC0DE0042, 32'h12345678};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h10C, 32'h0,        4, 1, 32'hC0DE0042, 32'hFFFFFFFF};
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].dr && tbl[i].dw) ref_mem[tbl[i].da[9:2]] = tbl[i].wd;
      run_step($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia,
               tbl[i].da, tbl[i].wd, tbl[i].exp_c, tbl[i].exp_en, tbl[i].exp_if, tbl[i].exp_d);
    end
    eif = tbl[6].exp_if;
    ed  = tbl[6].exp_d;

    // randomized transactions against a transaction-level model
    for (int i = 0; i < 150; i++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      da = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      wd = $urandom;
      ec = 0; een = 0;
      if (dr) begin
        een++;
        ec += dw ? 2 : LAT + 2;
        if (dw) ref_mem[da[9:2]] = wd;
        else    ed = ref_mem[da[9:2]];
      end
      if (ir) begin
        een++;
        if (dr) ec += 1;
        ec += LAT + 2;
        eif = ref_mem[ia[9:2]];
      end
      run_step($sformatf("rnd%0d", i), ir, dr, dw, ia, da, wd, ec, een, eif, ed);
    end
    idle(2);

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final mem mismatches", 32'(mism), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. It serialises requests, gives the MEM stage priority, and sequences each access through a fixed-latency wait. It produces the global `Stall` that freezes the pipeline until every outstanding request of the current cycle has completed. It sits between the `CPU` pipeline registers and the memory model.

## Interface
- `MEM_LAT`, default 2: cycles from `MemEn` to valid `MemRData`; must be ≥1.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `IFReq`  in  1  fetch request, held until the pipeline advances.
- `IFAddr`  in  ADDR_W  fetch address.
- `IFRData`  out  DATA_W  fetched instruction.
- `IFReady`  out  1  one-cycle completion pulse.
- `DReq`  in  1  data request, held until the pipeline advances.
- `DWrite`  in  1  1 = store, 0 = load.
- `DAddr`  in  ADDR_W  data address.
- `DWData`  in  DATA_W  store data.
- `DRData`  out  DATA_W  load data.
- `DReady`  out  1  one-cycle completion pulse.
- `MemEn`, `MemWe`  out  1  memory strobe and write enable.
- `MemAddr`  out  ADDR_W  memory address.
- `MemWData`  out  DATA_W  memory write data.
- `MemRData`  in  DATA_W  memory read data.
- `Stall`  out  1  pipeline hold.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **Pending requests:**
  - `pendD = DReq & ~DDone`
  - `pendIF = IFReq & ~IFDone`
- **Grant in IDLE:** `pendD` wins over `pendIF`. The grant latches owner, address, we and wdata, then goes to WAIT with `cnt` loaded.
  - `cnt` = `MEM_LAT` for a read.
  - `cnt` = 0 for a write.
- **WAIT:**
  - `MemEn` is high only in the first WAIT cycle.
  - `MemWe`, `MemAddr` and `MemWData` are registered and stable for the whole WAIT.
  - `cnt` decrements each cycle.
  - At `cnt == 0`, read data is captured from `MemRData` into the owner's RData register, and the FSM goes to RESP.
- **RESP:** the owner's Ready is high for this single cycle, then the FSM returns to IDLE. RData holds until the next completion on that port.
- **Done flags:** `IFDone` and `DDone`.
  - Set at the end of RESP if the owner's Req is still high.
  - Both clear at any edge where `Stall == 0`.
- **Stall equation:** `Stall = (IFReq & ~(IFDone|IFReady)) | (DReq & ~(DDone|DReady))`. It is combinational from flags, state and inputs.
- **Completed requests:** a held Req whose Done flag is set is never re-issued.
- **Flush:** if Req drops during WAIT or RESP, the access still completes and Ready still pulses, but no Done flag is set.
- **Reset:** `Rst` returns to IDLE immediately from any state.
  - `cnt`, Done flags, `MemEn`, `MemWe`, `MemAddr`, `MemWData`, `IFRData`, `DRData`, `IFReady` and `DReady` all go to 0.
  - Any in-flight memory response is discarded.
- **Signal behaviour:** writes return `DRData` unchanged. Address and data are passed through unmodified; there is no alignment checking.

## Timing
- **Read:** request seen in IDLE at cycle r.
  - `MemEn` in r+1.
  - Data sampled at the end of r+1+`MEM_LAT`.
  - Ready in r+`MEM_LAT`+2.
- **Write:** `MemEn` in r+1, Ready in r+2.
- **After RESP:** one IDLE cycle always follows RESP.
- **Two accesses in one stall:** the second grant occurs at r+`MEM_LAT`+3.
- **Pipeline advance:** happens on the edge ending the cycle where `Stall` is 0.
- **Reset values:** every output is 0 during reset. `Stall` follows its equation.

## Structure
- Shared package `cpu_mem_pkg`:
  - `arb_state_t` enum {IDLE, WAIT, RESP}.
  - `owner_t` enum {OWN_IF, OWN_D}.
  - Default `MEM_LAT`.
- One sub-module, `mem_lat_counter`: a loadable down-counter with a zero flag.
- Everything else stays in `mem_port_arbiter`.

## Test plan
Bench memory returns `MEM[addr]` after `MEM_LAT` = 2. The request cycle is 0.
1. **IF read alone:** `IFReq` with `IFAddr` = 0x00000004, `MEM` = 0x8C220000.
   - `MemEn` in cycle 1 only.
   - `IFReady` in cycle 4 with `IFRData` = 0x8C220000.
   - `Stall` = 1 in cycles 0–3, 0 in cycle 4.
2. **IF and D read together:** `IFReq` at 0x08 and `DReq` read at 0x40 (= 0x11) in the same cycle.
   - D is granted first: `DReady` in cycle 4 with `DRData` = 0x11.
   - `IF` `MemEn` in cycle 6, `IFReady` in cycle 9.
   - `Stall` = 1 through cycle 8, 0 in cycle 9.
   - Exactly two `MemEn` pulses.
3. **D store:** `DWrite` = 1, `DAddr` = 0x40, `DWData` = 0x000000AA.
   - `MemEn` = `MemWe` = 1 in cycle 1.
   - `DReady` in cycle 2.
   - `MEM[0x40]` = 0xAA.
4. **Reset mid-read:** `Rst` pulsed in cycle 2 of an IF read.
   - All outputs 0, and no `IFReady`.
   - After release with `IFReq` held, a fresh `MemEn` occurs one cycle later.
5. **Flush:** `IFReq` dropped in cycle 2 of a read.
   - `IFReady` still pulses in cycle 4.
   - `Stall` = 0 from cycle 2.
   - No `IFDone`.
   - A new `IFReq` at cycle 6 issues normally.
6. **No re-issue:** `DReq` held while an IF read is still pending.
   - D is issued once only.
   - `DDone` is set, and `Stall` stays 1 until `IFReady`.
